bit_count_pipe: RTL and testbench



---
 rtl/bitutils_pkg.sv | 19 +
 rtl/bit_chunk_count.sv | 36 +++
 rtl/bit_count_pipe.sv | 170 +++++++++++++++++
 tb/tb_bit_count_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitutils_pkg.sv
// Shared bit-manipulation types for the ALU backend: op encoding,
// count-width helper and the machine word type.
package bitutils;

   typedef enum logic [1:0] {
      CLZ  = 2'd0,
      CTZ  = 2'd1,
      CPOP = 2'd2
   } bitop_e;

   localparam int XLEN = 64;
   typedef logic [XLEN-1:0] word_t;

   // A count over `width` bits ranges 0..width inclusive.
   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/bit_chunk_count.sv
// Combinational per-chunk counter: leading zeros, trailing zeros,
// population count and all-zero flag of one CHUNK-bit slice.
module bit_chunk_count #(
   parameter int CHUNK = 8,
   parameter int CW    = $clog2(CHUNK) + 1
) (
   input  logic [CHUNK-1:0] data_i,
   output logic [CW-1:0]    lz_o,
   output logic [CW-1:0]    tz_o,
   output logic [CW-1:0]    pop_o,
   output logic             zero_o
);

   // lz scans upward so the highest set bit wins; tz scans downward so the
   // lowest set bit wins. The two scans share nothing.
   always_comb begin
      lz_o = CW'(CHUNK);
      for (int i = 0; i < CHUNK; i++)
         if (data_i[i]) lz_o = CW'(CHUNK - 1 - i);
   end

   always_comb begin
      tz_o = CW'(CHUNK);
      for (int i = CHUNK - 1; i >= 0; i--)
         if (data_i[i]) tz_o = CW'(i);
   end

   always_comb begin
      pop_o = '0;
      for (int i = 0; i < CHUNK; i++)
         pop_o = pop_o + CW'(data_i[i]);
   end

   assign zero_o = ~|data_i;

endmodule

// File: rtl/bit_count_pipe.sv
// Two-stage CLZ/CTZ/CPOP unit with valid/ready handshake, tag passthrough,
// flush, and optional RV64 32-bit word mode.
module bit_count_pipe
   import bitutils::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int TAG_W = 5,
   parameter int HAS_W = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  bitop_e           in_op,
   input  logic             in_wmode,
   input  logic [WIDTH-1:0] in_value,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NCH   = WIDTH / CHUNK;
   localparam int NCH_W = 32 / CHUNK;
   localparam int CW    = $clog2(CHUNK) + 1;
   localparam int RW    = cnt_w(WIDTH);

   logic             wmode_in;
   logic [WIDTH-1:0] eff_val;
   logic [CW-1:0]    c_lz  [NCH];
   logic [CW-1:0]    c_tz  [NCH];
   logic [CW-1:0]    c_pop [NCH];
   logic [NCH-1:0]   c_zero;

   logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic             s1_en, s2_en, accept, load_p2;

   logic [CW-1:0]    lz_p1_q  [NCH];
   logic [CW-1:0]    tz_p1_q  [NCH];
   logic [CW-1:0]    pop_p1_q [NCH];
   logic [NCH-1:0]   zero_p1_q;
   bitop_e           op_p1_q;
   logic             wm_p1_q;
   logic [TAG_W-1:0] tag_p1_q;

   logic [RW-1:0]    res_p2_q, res_p2_d;
   logic             zero_p2_q, zero_p2_d;
   logic [TAG_W-1:0] tag_p2_q;

   assign wmode_in = (HAS_W != 0) && in_wmode;

   // Word mode zeroes the upper half so those chunks read as all-zero.
   always_comb begin
      eff_val = in_value;
      if (wmode_in)
         for (int i = 32; i < WIDTH; i++) eff_val[i] = 1'b0;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chunk
      bit_chunk_count #(.CHUNK(CHUNK)) u_chunk (
         .data_i (eff_val[g*CHUNK +: CHUNK]),
         .lz_o   (c_lz[g]),
         .tz_o   (c_tz[g]),
         .pop_o  (c_pop[g]),
         .zero_o (c_zero[g])
      );
   end

   assign s2_en    = !vld_p2_q || out_ready;
   assign s1_en    = !vld_p1_q || s2_en;
   assign in_ready = s1_en && !flush;
   assign accept   = in_valid && in_ready;
   assign load_p2  = s2_en && vld_p1_q;

   always_comb begin
      vld_p1_d = s1_en ? accept : vld_p1_q;
      vld_p2_d = s2_en ? vld_p1_q : vld_p2_q;
      if (flush) begin
         vld_p1_d = 1'b0;
         vld_p2_d = 1'b0;
      end
   end

   // ---- stage 1: per-chunk counts ----
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < NCH; c++) begin
            lz_p1_q[c]  <= c_lz[c];
            tz_p1_q[c]  <= c_tz[c];
            pop_p1_q[c] <= c_pop[c];
         end
         zero_p1_q <= c_zero;
         op_p1_q   <= in_op;
         wm_p1_q   <= wmode_in;
         tag_p1_q  <= in_tag;
      end
   end

   // Chunks above the effective width are skipped, so an all-zero operand
   // naturally accumulates to EW for CLZ/CTZ.
   always_comb begin
      int            nch_eff;
      logic [RW-1:0] clz_acc, ctz_acc, pop_acc;
      logic          clz_done, ctz_done, all_zero;
      nch_eff  = wm_p1_q ? NCH_W : NCH;
      clz_acc  = '0;
      ctz_acc  = '0;
      pop_acc  = '0;
      clz_done = 1'b0;
      ctz_done = 1'b0;
      all_zero = 1'b1;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (c < nch_eff && !clz_done) begin
            if (zero_p1_q[c]) clz_acc = clz_acc + RW'(CHUNK);
            else begin
               clz_acc  = clz_acc + RW'(lz_p1_q[c]);
               clz_done = 1'b1;
            end
         end
      end
      for (int c = 0; c < NCH; c++) begin
         if (c < nch_eff) begin
            pop_acc  = pop_acc + RW'(pop_p1_q[c]);
            all_zero = all_zero & zero_p1_q[c];
            if (!ctz_done) begin
               if (zero_p1_q[c]) ctz_acc = ctz_acc + RW'(CHUNK);
               else begin
                  ctz_acc  = ctz_acc + RW'(tz_p1_q[c]);
                  ctz_done = 1'b1;
               end
            end
         end
      end
      case (op_p1_q)
         CLZ:     res_p2_d = clz_acc;
         CTZ:     res_p2_d = ctz_acc;
         default: res_p2_d = pop_acc;
      endcase
      zero_p2_d = all_zero;
   end

   // ---- stage 2: combined result / output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         res_p2_q  <= '0;
         zero_p2_q <= 1'b0;
         tag_p2_q  <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         if (load_p2) begin
            res_p2_q  <= res_p2_d;
            zero_p2_q <= zero_p2_d;
            tag_p2_q  <= tag_p1_q;
         end
      end
   end

   assign out_valid  = vld_p2_q;
   assign out_result = {{(WIDTH-RW){1'b0}}, res_p2_q};
   assign out_zero   = zero_p2_q;
   assign out_tag    = tag_p2_q;

endmodule

// File: tb/tb_bit_count_pipe.sv
// Self-checking bench for bit_count_pipe: a 32-bit instance for normal-mode
// behaviour and a 64-bit word-mode instance, both against a reference model.
module tb_bit_count_pipe;
   import bitutils::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        a_flush, a_in_valid, a_in_ready, a_in_wmode, a_out_valid, a_out_ready, a_out_zero;
   bitop_e      a_in_op;
   logic [31:0] a_in_value, a_out_result;
   logic [4:0]  a_in_tag, a_out_tag;

   logic        b_flush, b_in_valid, b_in_ready, b_in_wmode, b_out_valid, b_out_ready, b_out_zero;
   bitop_e      b_in_op;
   logic [63:0] b_in_value, b_out_result;
   logic [4:0]  b_in_tag, b_out_tag;

   bit_count_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5), .HAS_W(0)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_op(a_in_op), .in_wmode(a_in_wmode), .in_value(a_in_value), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
      .out_zero(a_out_zero), .out_tag(a_out_tag));

   bit_count_pipe #(.WIDTH(64), .CHUNK(8), .TAG_W(5), .HAS_W(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_op(b_in_op), .in_wmode(b_in_wmode), .in_value(b_in_value), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
      .out_zero(b_out_zero), .out_tag(b_out_tag));

   // Reference: plain bit-level arithmetic on the effective operand.
   function automatic void ref_model(input logic [1:0] op, input logic [63:0] val, input bit wm,
                                     input int width, output logic [63:0] res, output logic zero);
      logic [63:0] eff;
      int ew;
      ew  = wm ? 32 : width;
      eff = val;
      if (ew < 64) eff = val & ((64'd1 << ew) - 64'd1);
      zero = (eff == 64'd0);
      if (op == 2'd0) begin
         res = 64'(ew);
         for (int k = 0; k < ew; k++) if (eff[k]) res = 64'(ew - 1 - k);
      end else if (op == 2'd1) begin
         res = 64'(ew);
         for (int k = ew - 1; k >= 0; k--) if (eff[k]) res = 64'(k);
      end else begin
         res = 64'($countones(eff));
      end
   endfunction

   function automatic logic [31:0] rand32();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 4))
         0: v = v >> $urandom_range(0, 31);
         1: v = v << $urandom_range(0, 31);
         2: v = 32'd0;
         3: v = 32'hFFFF_FFFF;
         default: ;
      endcase
      return v;
   endfunction

   task automatic drain();
      a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_flush = 1'b0; a_in_valid = 1'b0; a_in_op = CLZ; a_in_wmode = 1'b0;
      a_in_value = '0; a_in_tag = '0; a_out_ready = 1'b1;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_op = CLZ; b_in_wmode = 1'b0;
      b_in_value = '0; b_in_tag = '0; b_out_ready = 1'b1;
      rst_n = 1'b0;
      #12;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
      checks++; if (a_out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result: got %0d want 0", a_out_result); end
      checks++; if (a_out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b want 0", a_out_zero); end
      checks++; if (a_out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag: got %0d want 0", a_out_tag); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
   endtask

   task automatic test_single_ops();
      bitop_e      d_op  [10];
      logic [31:0] d_val [10];
      logic [31:0] d_exp [10];
      logic        d_zr  [10];
      logic [63:0] m_res;
      logic        m_zero;
      logic [31:0] e_res;
      logic        e_zero;
      logic [4:0]  e_tag;
      d_op  = '{CLZ, CTZ, CPOP, CLZ, CTZ, CPOP, CLZ, CTZ, CTZ, CPOP};
      d_val = '{32'h0001_0000, 32'h0001_0000, 32'hF0F0_F0F0, 32'h0, 32'h0,
                32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0100, 32'h0};
      d_exp = '{32'd15, 32'd16, 32'd16, 32'd32, 32'd32, 32'd32, 32'd0, 32'd31, 32'd8, 32'd0};
      d_zr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      drain();
      for (int i = 0; i < 40; i++) begin
         if (i < 10) begin
            a_in_op = d_op[i]; a_in_value = d_val[i]; e_res = d_exp[i]; e_zero = d_zr[i];
         end else begin
            a_in_op = bitop_e'($urandom_range(0, 3));
            a_in_value = rand32();
            ref_model(a_in_op, {32'd0, a_in_value}, 1'b0, 32, m_res, m_zero);
            e_res = m_res[31:0]; e_zero = m_zero;
         end
         e_tag = 5'($urandom_range(0, 31));
         a_in_tag = e_tag; a_in_valid = 1'b1;
         checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready[%0d]: got %b want 1", i, a_in_ready); end
         @(posedge clk); #1;
         a_in_valid = 1'b0;
         checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %b want 0", i, a_out_valid); end
         @(posedge clk); #1;
         checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", i, a_out_valid); end
         checks++; if (a_out_result !== e_res) begin errors++; $display("FAIL single_result[%0d] op=%0d val=%h: got %0d want %0d", i, a_in_op, a_in_value, a_out_result, e_res); end
         checks++; if (a_out_zero !== e_zero) begin errors++; $display("FAIL single_zero[%0d]: got %b want %b", i, a_out_zero, e_zero); end
         checks++; if (a_out_tag !== e_tag) begin errors++; $display("FAIL single_tag[%0d]: got %0d want %0d", i, a_out_tag, e_tag); end
      end
   endtask

   task automatic test_back_to_back();
      bitop_e      ops  [6];
      logic [31:0] vals [6];
      logic [31:0] q_res [$];
      logic        q_zero [$];
      logic [4:0]  q_tag [$];
      logic [63:0] m_res;
      logic        m_zero;
      int issued, got, occ, cyc;
      logic acc, cons, exp_rdy;
      drain();
      for (int i = 0; i < 6; i++) begin
         ops[i]  = bitop_e'($urandom_range(0, 3));
         vals[i] = rand32();
      end
      issued = 0; got = 0; occ = 0; cyc = 0;
      while (got < 6 && cyc < 100) begin
         a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         a_in_valid  = (issued < 6);
         if (issued < 6) begin
            a_in_op = ops[issued]; a_in_value = vals[issued]; a_in_tag = 5'(issued + 1);
         end
         @(negedge clk);
         exp_rdy = !(occ == 2 && !a_out_ready);
         checks++; if (a_in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cyc=%0d: got %b want %b", cyc, a_in_ready, exp_rdy); end
         acc  = a_in_valid && a_in_ready;
         cons = a_out_valid && a_out_ready;
         if (a_out_valid) begin
            checks++;
            if (q_res.size() == 0) begin
               errors++; $display("FAIL b2b_spurious cyc=%0d: got valid tag %0d want no result", cyc, a_out_tag);
            end else if (a_out_result !== q_res[0] || a_out_zero !== q_zero[0] || a_out_tag !== q_tag[0]) begin
               errors++;
               $display("FAIL b2b_data cyc=%0d: got res=%0d zero=%b tag=%0d want res=%0d zero=%b tag=%0d",
                        cyc, a_out_result, a_out_zero, a_out_tag, q_res[0], q_zero[0], q_tag[0]);
            end
         end
         if (cons) begin
            got++;
            if (q_res.size() != 0) begin
               void'(q_res.pop_front()); void'(q_zero.pop_front()); void'(q_tag.pop_front());
            end
         end
         if (acc) begin
            ref_model(a_in_op, {32'd0, a_in_value}, 1'b0, 32, m_res, m_zero);
            q_res.push_back(m_res[31:0]); q_zero.push_back(m_zero); q_tag.push_back(a_in_tag);
            issued++;
         end
         occ = occ + (acc ? 1 : 0) - (cons ? 1 : 0);
         @(posedge clk); #1;
         cyc++;
      end
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      checks++; if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d results want 6", got); end
      checks++; if (q_res.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d pending want 0", q_res.size()); end
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_valid: got %b want 0", a_out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      drain();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_op = CPOP; a_in_value = 32'h0000_00FF; a_in_tag = 5'd11;
      @(posedge clk); #1;
      a_in_op = CLZ; a_in_value = 32'h0000_0001; a_in_tag = 5'd12;
      @(posedge clk); #1;
      a_in_op = CTZ; a_in_value = 32'h0000_0010; a_in_tag = 5'd13; a_flush = 1'b1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", a_in_ready); end
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL flush_full_valid: got %b want 1", a_out_valid); end
      checks++; if (a_out_tag !== 5'd11) begin errors++; $display("FAIL flush_head_tag: got %0d want 11", a_out_tag); end
      @(posedge clk); #1;
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got %b want 0", a_out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got valid tag %0d want 0", i, a_out_tag); end
      end
      a_in_valid = 1'b1; a_in_op = CTZ; a_in_value = 32'h0000_0100; a_in_tag = 5'd14;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", a_in_ready); end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_early: got %b want 0", a_out_valid); end
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_result !== 32'd8 || a_out_tag !== 5'd14) begin
         errors++;
         $display("FAIL flush_after_result: got valid=%b res=%0d tag=%0d want valid=1 res=8 tag=14", a_out_valid, a_out_result, a_out_tag);
      end
   endtask

   task automatic test_wmode();
      bitop_e      d_op  [6];
      logic [63:0] d_val [6];
      logic        d_wm  [6];
      logic [63:0] d_exp [6];
      logic        d_zr  [6];
      logic [63:0] m_res, e_res;
      logic        m_zero, e_zero;
      logic [4:0]  e_tag;
      d_op  = '{CLZ, CPOP, CTZ, CLZ, CLZ, CPOP};
      d_val = '{64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0000,
                64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0001};
      d_wm  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      d_exp = '{64'd31, 64'd1, 64'd32, 64'd0, 64'd32, 64'd33};
      d_zr  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      drain();
      for (int i = 0; i < 30; i++) begin
         if (i < 6) begin
            b_in_op = d_op[i]; b_in_value = d_val[i]; b_in_wmode = d_wm[i];
            e_res = d_exp[i]; e_zero = d_zr[i];
         end else begin
            b_in_op = bitop_e'($urandom_range(0, 3));
            b_in_value = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0: b_in_value = b_in_value >> $urandom_range(0, 63);
               1: b_in_value = b_in_value << $urandom_range(0, 63);
               2: b_in_value = 64'd0;
               default: ;
            endcase
            b_in_wmode = 1'($urandom_range(0, 1));
            ref_model(b_in_op, b_in_value, b_in_wmode, 64, m_res, m_zero);
            e_res = m_res; e_zero = m_zero;
         end
         e_tag = 5'($urandom_range(0, 31));
         b_in_tag = e_tag; b_in_valid = 1'b1;
         @(posedge clk); #1;
         b_in_valid = 1'b0;
         @(posedge clk); #1;
         checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL wmode_valid[%0d]: got %b want 1", i, b_out_valid); end
         checks++; if (b_out_result !== e_res) begin errors++; $display("FAIL wmode_result[%0d] op=%0d wm=%b val=%h: got %0d want %0d", i, b_in_op, b_in_wmode, b_in_value, b_out_result, e_res); end
         checks++; if (b_out_zero !== e_zero) begin errors++; $display("FAIL wmode_zero[%0d]: got %b want %b", i, b_out_zero, e_zero); end
         checks++; if (b_out_tag !== e_tag) begin errors++; $display("FAIL wmode_tag[%0d]: got %0d want %0d", i, b_out_tag, e_tag); end
      end
   endtask

   task automatic test_async_reset();
      drain();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_op = CLZ; a_in_value = 32'h0; a_in_tag = 5'd21;
      @(posedge clk); #1;
      a_in_op = CPOP; a_in_value = 32'h0000_000F; a_in_tag = 5'd22;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_result !== 32'd32 || a_out_zero !== 1'b1 || a_out_tag !== 5'd21) begin
         errors++;
         $display("FAIL rst_prefill: got valid=%b res=%0d zero=%b tag=%0d want 1/32/1/21", a_out_valid, a_out_result, a_out_zero, a_out_tag);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", a_out_valid); end
      checks++; if (a_out_result !== 32'd0) begin errors++; $display("FAIL rst_async_result: got %0d want 0", a_out_result); end
      checks++; if (a_out_zero !== 1'b0) begin errors++; $display("FAIL rst_async_zero: got %b want 0", a_out_zero); end
      checks++; if (a_out_tag !== 5'd0) begin errors++; $display("FAIL rst_async_tag: got %0d want 0", a_out_tag); end
      @(posedge clk); #3;
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", a_in_ready); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d]: got valid tag %0d want 0", i, a_out_tag); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_ops();
      test_back_to_back();
      test_flush();
      test_wmode();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
